phy_byte_serializer: RTL
========================

Name: phy_byte_serializer

Overview:
- Transmit-side PHY stage that consumes 32-bit words from the lane word source (data_in/valid_in) and emits one byte per clock, MSB first, toward the 8b/10b encoder.
- Sends COM control symbols after reset for lane synchronisation.
- Fills every byte slot with no data available with COM.
- Runs on the byte-rate clock clk_8f, which is 4x the word clock.

Parameters:
SYNC_COUNT, 4, number of COM symbols sent after reset release before the lane goes active (>=1)
COM_BYTE, 8'hBC, control byte (K28.5) used for sync and idle fill

Ports:
clk_8f  input  1  byte-rate clock, all logic on rising edge
reset  input  1  synchronous reset, active-high
data_in  input  32  word to serialise, byte [31:24] sent first
valid_in  input  1  data_in holds a valid word this cycle
ready_out  output  1  block can accept a word this cycle
byte_out  output  8  registered serial byte
k_out  output  1  registered; 1 = byte_out is a control symbol
active  output  1  registered; 1 = sync sequence complete, data path open

Behaviour:
- Interface (already decided): single clock clk_8f; reset is synchronous and active-high, sampled on clk_8f rising edge.
- Reset (reset=1 at an edge): byte_out=8'h00, k_out=0, active=0, ready_out=0, hold buffer empty, shifter empty (remaining count 0), sync counter 0, state SYNC.
- State SYNC:
  - Each edge with reset=0 drives byte_out=COM_BYTE, k_out=1 and increments the sync counter.
  - The first COM appears on the first edge after reset deasserts.
  - On the edge emitting the SYNC_COUNT-th COM, active is set to 1 and the state goes to RUN.
  - active rises together with the last sync COM.
- State RUN, per edge, in priority order:
  - Shifter has bytes remaining: output the next byte, k_out=0, decrement count.
  - Else hold buffer full: move hold into the shifter, output hold[31:24] with k_out=0, set remaining=3, mark hold empty.
  - Else output COM_BYTE with k_out=1.
- ready_out is combinational: active && !hold_full.
- Transfer occurs at an edge where valid_in && ready_out; data_in is written into the hold buffer.
- Acceptance and the hold-to-shifter move at the same edge are mutually exclusive: ready_out=0 whenever hold is full.
- Latency: a word accepted at edge N with the shifter idle puts its MSB on byte_out at edge N+1; its LSB appears at N+4.
- Throughput: with valid_in held high, data bytes are contiguous with no COM gaps. ready_out is high 1 cycle in every 4 in steady state.
- Word containing 8'hBC bytes: sent with k_out=0. Only k_out distinguishes data from control.
- valid_in=1 while active=0: ignored and not buffered. data_in is don't-care when valid_in=0.
- Reset mid-word: hold and shifter contents are discarded and the SYNC sequence restarts after release. No stale byte is ever emitted.
- Counters:
  - Sync counter is wide enough for SYNC_COUNT and saturates/stops in RUN.
  - Byte index is 2 bits and never wraps past 0 while reloading.

Test Plan:
1. Hold reset 3 edges, release -> byte_out=00/k=0 during reset. Then BC/k=1 on exactly 4 consecutive edges with active=0,0,0,1. ready_out first high the cycle after active rises. BC/k=1 continues while idle.
2. One transfer data_in=32'hDDCC_BBAA at edge N (idle) -> edges N+1..N+4 give DD,CC,BB,AA with k=0. Edge N+5 gives BC/k=1. ready_out is 0 in the cycle between N and N+1 only.
3. valid_in held 1 with FFFF_FFFF then EEEE_EEEE -> 8 contiguous bytes FF x4, EE x4, k=0, no BC between them. ready_out pulses once per 4 cycles.
4. Source pattern valid 1,1,0,0,1 over words FFFF_FFFF, EEEE_EEEE, DDDD_DDDD -> DDs appear only after EE bytes, with BC/k=1 filling exactly the empty slots. No word is duplicated or dropped; a scoreboard compares accepted words to the output bytes.
5. Reset asserted after 2 bytes of CCCC_CCCC, with a word pending in hold -> outputs 00/k=0 and active=0 during reset. After release, 4 BC/k=1 follow. No remaining CC byte and no held word ever appear.
6. data_in=32'hBCBC_BCBC -> four BC bytes with k_out=0, distinct from the surrounding BC/k=1 fill.

Source files
------------

// File: rtl/phy_byte_serializer.sv
// phy_byte_serializer: 32-bit word to MSB-first byte stream with COM sync and idle fill
module phy_byte_serializer #(
    parameter int          SYNC_COUNT = 4,
    parameter logic [7:0]  COM_BYTE   = 8'hBC
) (
    input  logic        clk_8f,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic [7:0]  byte_out,
    output logic        k_out,
    output logic        active
);
    localparam int SW = $clog2(SYNC_COUNT + 1);
    typedef enum logic {SYNC, RUN} state_t;
    state_t        state, state_n;
    logic [SW-1:0] sync_cnt, sync_cnt_n;
    logic [31:0]   hold, hold_n;
    logic          hold_full, hold_full_n;
    logic [23:0]   shift, shift_n;
    logic [1:0]    rem, rem_n;
    logic [7:0]    byte_n;
    logic          k_n, active_n;
    assign ready_out = active && !hold_full;
    // Next-state: sync COM burst, then shifter drains before hold reloads, COM fills empty slots
    always_comb begin
        state_n     = state;
        sync_cnt_n  = sync_cnt;
        hold_n      = hold;
        hold_full_n = hold_full;
        shift_n     = shift;
        rem_n       = rem;
        active_n    = active;
        byte_n      = COM_BYTE;
        k_n         = 1'b1;
        if (state == SYNC) begin
            sync_cnt_n = sync_cnt + 1'b1;
            if (sync_cnt == SW'(SYNC_COUNT - 1)) begin
                active_n = 1'b1;
                state_n  = RUN;
            end
        end else if (rem != 2'd0) begin
            byte_n  = shift[23:16];
            k_n     = 1'b0;
            shift_n = {shift[15:0], 8'h00};
            rem_n   = rem - 2'd1;
        end else if (hold_full) begin
            byte_n      = hold[31:24];
            k_n         = 1'b0;
            shift_n     = hold[23:0];
            rem_n       = 2'd3;
            hold_full_n = 1'b0;
        end
        if (valid_in && ready_out) begin
            hold_n      = data_in;
            hold_full_n = 1'b1;
        end
    end
    // State register; reset discards any buffered word so nothing stale is emitted
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state     <= SYNC;
            sync_cnt  <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            shift     <= '0;
            rem       <= 2'd0;
            byte_out  <= 8'h00;
            k_out     <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_n;
            sync_cnt  <= sync_cnt_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            shift     <= shift_n;
            rem       <= rem_n;
            byte_out  <= byte_n;
            k_out     <= k_n;
            active    <= active_n;
        end
    end
endmodule
